sample_sched: RTL and testbench
===============================

# sample_sched

Round-robin scheduler that shares the single two-phase sampling stage (arm cycle, then capture cycle) among NREQ requesters. It picks one pending requester, runs the arm and capture phases on its data word, and returns the sampled word tagged with the requester index. It also acknowledges the winning requester. The block sits between the requester ports and the downstream consumer of sampled data, replacing the free-running toggle sampler wherever more than one source needs the stage.

## Interface
- NREQ, 4, number of requesters (2..16)
- DW, 8, data word width
- IDW, derived = clog2(NREQ), width of requester index (localparam, not overridable)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  grant enable; low blocks new grants only
- req  in  NREQ  per-requester request level, held until acked
- din  in  NREQ*DW  requester data, requester i at bits [i*DW +: DW]
- ack  out  NREQ  one-cycle registered pulse to the served requester
- out_valid  out  1  one-cycle registered pulse, sample available
- out_data  out  DW  sampled word, holds until next capture
- out_id  out  IDW  index of the requester whose word is in out_data
- busy  out  1  high when the FSM is not IDLE (decoded from the state register)

## Operation
- States: IDLE, ARM, CAPT.
- IDLE:
  - Pending vector = req & ~ack. A requester whose ack is high this cycle is ignored, which prevents a double grant on the cycle the requester drops req.
  - If en=1 and pending is non-zero:
    - gnt_id <= first pending index searching last_grant+1, +2, … modulo NREQ.
    - Next state ARM.
  - Otherwise remain in IDLE.
- ARM: one cycle, no datapath action.
  - If req[gnt_id]=0, abort to IDLE.
  - Otherwise go to CAPT.
- CAPT:
  - If req[gnt_id]=0, abort to IDLE. On abort: no ack, no out_valid, last_grant unchanged.
  - Otherwise:
    - out_data <= din[gnt_id], out_id <= gnt_id, out_valid <= 1.
    - ack[gnt_id] <= 1, last_grant <= gnt_id.
    - Next state IDLE.
- ack and out_valid self-clear the following cycle.
- en=0 while in ARM or CAPT: the transaction completes normally.
- din is sampled only at the CAPT edge. Changes to din earlier in the transaction are not seen.
- Reset values: state=IDLE, gnt_id=0, last_grant=NREQ-1 (so requester 0 has first priority), ack=0, out_valid=0, out_data=0, out_id=0, busy=0.
- Reset asserted mid-transaction: all registers take their reset values immediately (asynchronous). The transaction is lost and no ack is issued.

## Timing
- Request seen at edge E0 (FSM in IDLE) -> ARM after E0 -> CAPT after E1.
- ack, out_valid, out_data and out_id update at E2; the pulses are high between E2 and E3.
- Latency from req sampled to out_valid = 2 edges.
- Requester contract: deassert req at E3 or later, after seeing ack. Keeping req high beyond E3 is taken as a new request.
- Maximum throughput: one sample per 3 cycles. The next grant decision is made at E3 while ack is still visible.
- Fairness: with all NREQ requesters continuously pending, each is served exactly once per 3*NREQ cycles.
- busy rises the cycle after E0 and falls after E2, or after the abort edge.

## Structure
- Package sample_sched_pkg:
  - State encoding constants: IDLE=2'd0, ARM=2'd1, CAPT=2'd2.
  - clog2 function, used for IDW.
- Sub-module rr_pick: combinational round-robin select.
  - Inputs: pending[NREQ], last[IDW].
  - Outputs: any, idx[IDW].
  - Reusable by other arbiters in the design.
- Top level holds the FSM, the gnt_id/last_grant registers, the output registers and the din mux.

## Test plan
- Single requester: reset, release, req[0]=1 with din0=8'hA5 at E0 -> out_valid=1, out_data=8'hA5, out_id=0, ack=4'b0001 after E2, busy high for exactly 2 cycles.
- All four requesters held high, din_i=8'h10+i -> out_id sequence 0,1,2,3,0. out_valid every 3rd cycle, out_data 8'h10, 8'h11, 8'h12, 8'h13.
- After serving id 2, req[1] and req[3] raised together -> id 3 granted first, then id 1.
- Abort: req[1] granted, then dropped during ARM -> no out_valid, no ack, state IDLE next cycle. A following req[1] is granted again before req[2].
- en=0 with req=4'b1111 -> no grant for 10 cycles. Drop en during CAPT -> capture completes, then no further grant.
- rst asserted during ARM -> ack, out_valid, out_data and busy read 0 immediately. After release with req=4'b1010, id 1 is granted first.

Source files
------------

// File: rtl/sample_sched_pkg.sv
// sample_sched shared types and helpers.
// State encoding and index-width function.
package sample_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    CAPT = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/sample_sched_if.sv
// Requester-side and consumer-side bundle.
// master drives requests, slave is the scheduler.
interface sample_sched_if
  import sample_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IDW = clog2(NREQ);

  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]   ack;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic              busy;

  modport master (
    output en, req, din,
    input  ack, out_valid, out_data,
    input  out_id, busy
  );

  modport slave (
    input  en, req, din,
    output ack, out_valid, out_data,
    output out_id, busy
  );
endinterface

// File: rtl/sample_sched_rr_pick.sv
// Combinational round-robin pick.
// Searches last+1, last+2, ... modulo NREQ.
module rr_pick
  import sample_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [IDW-1:0]  last_i,
  output logic            any_o,
  output logic [IDW-1:0]  idx_o
);

  // farthest candidate first so the nearest one wins
  always_comb begin
    int c;
    any_o = 1'b0;
    idx_o = '0;
    c     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      c = (int'(last_i) + k) % NREQ;
      if (pending_i[c]) begin
        any_o = 1'b1;
        idx_o = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/sample_sched.sv
// Round-robin scheduler for the shared
// two-phase sampling stage.
module sample_sched
  import sample_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input logic          clk,
  input logic          rst,
  sample_sched_if.slave bus
);
  localparam int IDW = clog2(NREQ);

  state_t          state_q, state_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [NREQ-1:0] pending;
  logic [DW-1:0]   din_sel;
  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic            gnt_req;
  logic            grant;
  logic            capture;
  logic            busy;

  // acked requester is masked to avoid a double grant
  assign pending = bus.req & ~ack_q;
  assign gnt_req = bus.req[gnt_id_q];
  assign din_sel = bus.din[int'(gnt_id_q)*DW +: DW];

  rr_pick #(.NREQ(NREQ)) u_pick (
    .pending_i (pending),
    .last_i    (last_q),
    .any_o     (pick_any),
    .idx_o     (pick_idx)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic; en gates only new grants
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.en && pick_any) state_d = ARM;
      ARM:  state_d = gnt_req ? CAPT : IDLE;
      CAPT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath next-state
  always_comb begin
    grant       = (state_q == IDLE) && bus.en && pick_any;
    capture     = (state_q == CAPT) && gnt_req;
    busy        = (state_q != IDLE);
    gnt_id_d    = gnt_id_q;
    last_d      = last_q;
    ack_d       = '0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (grant) gnt_id_d = pick_idx;
    if (capture) begin
      out_data_d      = din_sel;
      out_id_d        = gnt_id_q;
      out_valid_d     = 1'b1;
      ack_d[gnt_id_q] = 1'b1;
      last_d          = gnt_id_q;
    end
  end

  // datapath registers; last starts at NREQ-1 so 0 wins first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_id_q    <= '0;
      last_q      <= IDW'(NREQ - 1);
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      gnt_id_q    <= gnt_id_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_sample_sched.sv
// Randomized and directed bench for sample_sched
// against a transaction-level reference model.
module tb_sample_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk;
  logic rst;

  sample_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  sample_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // reference model: a transaction granted at cycle g
  // captures at g+2 unless its req drops before then
  int              cyc;
  bit              m_in;
  int              m_gcyc;
  int              m_id;
  int              m_last;
  logic [NREQ-1:0] m_ack;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  int              m_oid;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_in    = 1'b0;
    m_id    = 0;
    m_last  = NREQ - 1;
    m_ack   = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_oid   = 0;
  endfunction

  function automatic void m_edge();
    logic [NREQ-1:0] pend;
    pend    = bus.req & ~m_ack;
    m_ack   = '0;
    m_valid = 1'b0;
    if (!m_in) begin
      if (bus.en && pend != '0) begin
        for (int k = NREQ; k >= 1; k--)
          if (pend[(m_last + k) % NREQ]) m_id = (m_last + k) % NREQ;
        m_in   = 1'b1;
        m_gcyc = cyc;
      end
    end else if (!bus.req[m_id]) begin
      m_in = 1'b0;
    end else if (cyc == m_gcyc + 2) begin
      m_data       = bus.din[m_id*DW +: DW];
      m_oid        = m_id;
      m_valid      = 1'b1;
      m_ack[m_id]  = 1'b1;
      m_last       = m_id;
      m_in         = 1'b0;
    end
    cyc++;
  endfunction

  task automatic cmp_all(string tag);
    chk({tag, ".ack"},   32'(bus.ack),       32'(m_ack));
    chk({tag, ".vld"},   32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, ".id"},    32'(bus.out_id),    32'(m_oid));
    chk({tag, ".busy"},  32'(bus.busy),      32'(m_in));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    m_edge();
    #1;
    cmp_all(tag);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    cmp_all("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // wait for the next sample, bounded
  task automatic next_id(string tag, output int id);
    id = -1;
    for (int i = 0; i < 20 && id < 0; i++) begin
      tick(tag);
      if (bus.out_valid === 1'b1) id = int'(bus.out_id);
    end
    if (id < 0) chk({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  int id;
  int bcnt;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    m_gcyc = 0;
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.req = '0;
    bus.din = '0;
    m_reset();
    @(negedge clk);
    do_reset();

    // single requester
    bus.din[7:0] = 8'hA5;
    bus.req = 4'b0001;
    bcnt = 0;
    tick("s0"); bcnt += int'(bus.busy);
    tick("s1"); bcnt += int'(bus.busy);
    tick("s2"); bcnt += int'(bus.busy);
    chk("s.vld",  32'(bus.out_valid), 32'd1);
    chk("s.data", 32'(bus.out_data),  32'hA5);
    chk("s.id",   32'(bus.out_id),    32'd0);
    chk("s.ack",  32'(bus.ack),       32'b0001);
    chk("s.bcnt", 32'(bcnt),          32'd2);
    bus.req = '0;
    tick("s3");
    chk("s.idle", 32'(bus.busy), 32'd0);

    // all four held: 0,1,2,3,0 every third cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) bus.din[i*DW +: DW] = 8'(8'h10 + i);
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      next_id("rr", id);
      chk("rr.seq",  32'(id), 32'(n % NREQ));
      chk("rr.data", 32'(bus.out_data), 32'(8'h10 + (n % NREQ)));
      if (n > 0) chk("rr.gap", 32'(cyc - bcnt), 32'd3);
      bcnt = cyc;
    end
    bus.req = '0;
    repeat (3) tick("rr.d");

    // after id 2, raise 1 and 3 together
    do_reset();
    bus.req = 4'b0100;
    next_id("p2", id);
    chk("p2.id", 32'(id), 32'd2);
    bus.req = 4'b1010;
    next_id("p3", id);
    chk("p3.id", 32'(id), 32'd3);
    bus.req = 4'b0010;
    next_id("p1", id);
    chk("p1.id", 32'(id), 32'd1);
    bus.req = '0;
    repeat (2) tick("p.d");

    // abort during ARM
    do_reset();
    bus.req = 4'b0010;
    tick("ab0");
    bus.req = '0;
    tick("ab1");
    chk("ab.busy", 32'(bus.busy), 32'd0);
    tick("ab2");
    chk("ab.vld",  32'(bus.out_valid), 32'd0);
    bus.req = 4'b0110;
    next_id("ab3", id);
    chk("ab.regnt", 32'(id), 32'd1);
    bus.req = '0;
    repeat (2) tick("ab.d");

    // en low blocks grants; drop en in CAPT
    bus.en  = 1'b0;
    bus.req = 4'b1111;
    repeat (10) begin
      tick("en0");
      chk("en0.busy", 32'(bus.busy), 32'd0);
    end
    bus.en = 1'b1;
    tick("en1");
    tick("en2");
    bus.en = 1'b0;
    tick("en3");
    chk("en.cap", 32'(bus.out_valid), 32'd1);
    repeat (5) tick("en4");
    bus.req = '0;
    bus.en  = 1'b1;
    tick("en5");

    // reset during ARM
    bus.req = 4'b1010;
    tick("ra0");
    chk("ra.busy", 32'(bus.busy), 32'd1);
    do_reset();
    chk("ra.z", 32'({bus.ack, bus.out_valid, bus.out_data, bus.busy}), 32'd0);
    next_id("ra1", id);
    chk("ra.first", 32'(id), 32'd1);
    bus.req = '0;
    repeat (2) tick("ra.d");

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bus.en = ($urandom % 8) != 0;
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack[i])        bus.req[i] = 1'($urandom % 2);
        else if (!bus.req[i]) bus.req[i] = ($urandom % 3) == 0;
        else                 bus.req[i] = ($urandom % 16) != 0;
      end
      bus.din = $urandom;
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
